// File: rtl/srl_sra_pipe.sv
// srl_sra_pipe: five-stage pipelined 32-bit right shifter (srl/sra) with
// valid/ready flow control, backpressure and synchronous flush.
// Stage k consumes shamt bit SHW-k, so the big shifts happen first.
// WIDTH must equal 2**SHW.

// One pipeline slot: loads the previous slot's operation, shifted by
// 2**BIT when that shamt bit is set, whenever the slot is free to load.
module srl_sra_stage #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int TAGW  = 5,
    parameter int BIT   = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load_en,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic [SHW-1:0]   prev_shamt,
    input  logic             prev_arith,
    input  logic [TAGW-1:0]  prev_tag,
    output logic             valid_q,
    output logic [WIDTH-1:0] data_q,
    output logic [SHW-1:0]   shamt_q,
    output logic             arith_q,
    output logic [TAGW-1:0]  tag_q
);
    localparam int AMT = 1 << BIT;

    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic [SHW-1:0]   shamt_d;
    logic             arith_d;
    logic [TAGW-1:0]  tag_d;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    // Shift by this slot's fixed amount; sra fills with the incoming MSB,
    // which is still the original sign bit.
    always_comb begin
        fill      = {WIDTH{prev_arith & prev_data[WIDTH-1]}};
        fill_mask = ~({WIDTH{1'b1}} >> AMT);
        shifted   = prev_shamt[BIT] ? ((prev_data >> AMT) | (fill & fill_mask))
                                    : prev_data;
    end

    // Next-state: take the upstream op when free, hold otherwise; payload
    // only moves with a valid op so an empty slot keeps its old contents.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        shamt_d = shamt_q;
        arith_d = arith_q;
        tag_d   = tag_q;
        if (load_en) begin
            valid_d = prev_valid;
            if (prev_valid) begin
                data_d  = shifted;
                shamt_d = prev_shamt & ~(SHW'(1) << BIT);
                arith_d = prev_arith;
                tag_d   = prev_tag;
            end
        end
        if (flush) valid_d = 1'b0;
    end

    // Slot registers, cleared by the asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            arith_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
            tag_q   <= tag_d;
        end
    end
endmodule

module srl_sra_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int TAGW  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_arith,
    input  logic [TAGW-1:0]  in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAGW-1:0]  out_tag,
    output logic             busy
);
    // Index 0 is the input port, 1..SHW are the registered stages.
    logic [SHW:0]                vld_pipe;
    logic [SHW:0][WIDTH-1:0]     data_pipe;
    logic [SHW:0][SHW-1:0]       shamt_pipe;
    logic [SHW:0]                arith_pipe;
    logic [SHW:0][TAGW-1:0]      tag_pipe;
    // free[k]: stage k may load this cycle (empty, or its op moves on).
    logic [SHW+1:1]              free;
    logic                        unused_shamt;

    assign vld_pipe[0]   = in_valid;
    assign data_pipe[0]  = in_data;
    assign shamt_pipe[0] = in_shamt;
    assign arith_pipe[0] = in_arith;
    assign tag_pipe[0]   = in_tag;
    assign free[SHW+1]   = out_ready;

    for (genvar k = 1; k <= SHW; k++) begin : g_stage
        // Bubbles collapse: an empty stage is always free.
        assign free[k] = !vld_pipe[k] | free[k+1];

        srl_sra_stage #(
            .WIDTH(WIDTH), .SHW(SHW), .TAGW(TAGW), .BIT(SHW - k)
        ) u_stage (
            .clock     (clock),
            .reset_n   (reset_n),
            .flush     (flush),
            .load_en   (free[k]),
            .prev_valid(vld_pipe[k-1]),
            .prev_data (data_pipe[k-1]),
            .prev_shamt(shamt_pipe[k-1]),
            .prev_arith(arith_pipe[k-1]),
            .prev_tag  (tag_pipe[k-1]),
            .valid_q   (vld_pipe[k]),
            .data_q    (data_pipe[k]),
            .shamt_q   (shamt_pipe[k]),
            .arith_q   (arith_pipe[k]),
            .tag_q     (tag_pipe[k])
        );
    end

    // The last stage's leftover shamt bits are all consumed by then.
    assign unused_shamt = ^{shamt_pipe[SHW], arith_pipe[SHW]};

    assign in_ready  = free[1];
    assign out_valid = vld_pipe[SHW];
    assign out_data  = data_pipe[SHW];
    assign out_tag   = tag_pipe[SHW];
    assign busy      = |vld_pipe[SHW:1];
endmodule

// File: tb/tb_srl_sra_pipe.sv
// Directed bench for srl_sra_pipe with a queue scoreboard: expected results
// are pushed on each accepted input and popped as results leave.
module tb_srl_sra_pipe;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    int          cyc;
    int          lat;
  } exp_t;

  logic        clock, reset_n;
  logic        in_valid, in_ready, in_arith, flush;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic        out_valid, out_ready, busy;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          pops = 0;
  logic        acc;
  logic [31:0] cur_exp;
  int          cur_lat;
  exp_t        exp_q[$];

  srl_sra_pipe #(.WIDTH(32), .SHW(5), .TAGW(5)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_arith(in_arith), .in_tag(in_tag),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s,
                                        input logic a);
    logic [31:0] r;
    if (a) r = 32'($signed(d) >>> s);
    else   r = d >> s;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score outputs/inputs, return just after posedge.
  task automatic step();
    exp_t e;
    @(negedge clock);
    cyc++;
    acc = 1'b0;
    if (out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_out: observed tag=%h data=%h expected none", out_tag, out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        pops++;
        chk("out_data", out_data, e.data);
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        if (e.lat != 0) chk("latency", 32'(cyc - e.cyc), 32'(e.lat));
      end
    end
    if (flush) exp_q.delete();
    if (in_valid && in_ready && !flush && reset_n) begin
      e.data = cur_exp; e.tag = in_tag; e.cyc = cyc; e.lat = cur_lat;
      exp_q.push_back(e);
      acc = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                        input logic [4:0] tg, input logic [31:0] ex, input int lat);
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_arith = ar; in_tag = tg;
    cur_exp = ex; cur_lat = lat;
  endtask

  task automatic offer(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                       input logic [4:0] tg, input logic [31:0] ex, input int lat);
    set_op(d, sh, ar, tg, ex, lat);
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc) break;
    end
    in_valid = 1'b0;
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout: observed pending=%0d expected 0", exp_q.size());
    end
    repeat (3) step();
  endtask

  initial begin
    int c0, n_acc, p0;
    logic [31:0] sd[7];
    logic [4:0]  ss[7];
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_arith = 1'b0;
    in_tag = '0; flush = 1'b0; out_ready = 1'b1; cur_exp = '0; cur_lat = 0;

    // Reset values
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic srl / sra with 5-cycle latency
    offer(32'hF0F01234, 5'd4, 1'b0, 5'd3, 32'h0F0F0123, 5);
    offer(32'hF0F01234, 5'd4, 1'b1, 5'd4, 32'hFF0F0123, 5);
    drain();

    // Boundaries
    offer(32'h80000000, 5'd31, 1'b0, 5'd1, 32'h00000001, 5);
    offer(32'h80000000, 5'd31, 1'b1, 5'd2, 32'hFFFFFFFF, 5);
    offer(32'h80000000, 5'd0,  1'b0, 5'd5, 32'h80000000, 5);
    offer(32'h80000000, 5'd0,  1'b1, 5'd6, 32'h80000000, 5);
    offer(32'h7FFFFFFF, 5'd5,  1'b0, 5'd7, 32'h03FFFFFF, 5);
    offer(32'h7FFFFFFF, 5'd5,  1'b1, 5'd8, 32'h03FFFFFF, 5);
    drain();

    // Back-to-back stream, one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 32; i++)
      offer(32'hDEADBEEF, 5'(i), i[0], 5'(i), model(32'hDEADBEEF, 5'(i), i[0]), 5);
    chk("stream_cycles", 32'(cyc - c0), 32);
    drain();

    // Stall: 7 offered, 5 held
    for (int i = 0; i < 7; i++) begin
      sd[i] = 32'hA5A50000 + 32'(i);
      ss[i] = 5'(i + 1);
    end
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      set_op(sd[n_acc], ss[n_acc], 1'b1, 5'(10 + n_acc), model(sd[n_acc], ss[n_acc], 1'b1), 0);
      step();
      if (acc) n_acc++;
    end
    chk("stall_accepted", 32'(n_acc), 5);
    chk("stall_in_ready", 32'(in_ready), 0);
    chk("stall_out_valid", 32'(out_valid), 1);
    chk("stall_out_data", out_data, 32'hD2D28000);
    repeat (2) begin
      step();
      if (acc) n_acc++;
    end
    chk("stall_hold_data", out_data, 32'hD2D28000);
    chk("stall_hold_acc", 32'(n_acc), 5);
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 5; i++) begin
      if (n_acc < 7)
        set_op(sd[n_acc], ss[n_acc], 1'b1, 5'(10 + n_acc), model(sd[n_acc], ss[n_acc], 1'b1), 0);
      else in_valid = 1'b0;
      step();
      if (acc) n_acc++;
    end
    chk("release_pops", 32'(pops - p0), 5);
    chk("release_accepted", 32'(n_acc), 7);
    drain();

    // Flush with 3 ops in flight plus a same-cycle input
    offer(32'h11111111, 5'd1, 1'b0, 5'd20, 32'h08888888, 0);
    offer(32'h22222222, 5'd2, 1'b0, 5'd21, 32'h08888888, 0);
    offer(32'h33333333, 5'd3, 1'b0, 5'd22, 32'h06666666, 0);
    set_op(32'h44444444, 5'd4, 1'b0, 5'd23, 32'h04444444, 0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", 32'(busy), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    repeat (8) step();
    offer(32'hC0000000, 5'd2, 1'b1, 5'd24, 32'hF0000000, 5);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 8; i++)
      offer(32'h0F0F0F0F, 5'(i), 1'b0, 5'(i), model(32'h0F0F0F0F, 5'(i), 1'b0), 5);
    chk("pre_rst_out_valid", 32'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_tag", 32'(out_tag), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    repeat (2) step();
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    offer(32'h00000100, 5'd8, 1'b0, 5'd9, 32'h00000001, 5);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/srl_sra_pipe.md
Name: srl_sra_pipe

Overview:
- Pipelined 32-bit right barrel shifter. Performs logical (srl) and arithmetic (sra) right shifts for the execute stage.
- Complements the combinational left shifter in the ALU.
- Five register stages, one per shamt bit (16, 8, 4, 2, 1), with valid/ready handshake, downstream backpressure and synchronous flush.
- The 5-bit tag is carried alongside each result so writeback can steer it (e.g. destination register).

Parameters:
- WIDTH, 32, data width; must equal 2**SHW.
- SHW, 5, shamt width; also the number of pipeline stages.
- TAGW, 5, width of the sideband tag carried with each operation.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered this cycle
- in_ready  output  1  pipeline accepts the offered operation this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..31
- in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- in_tag  input  TAGW  sideband tag
- flush  input  1  synchronous kill of all in-flight operations
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result this cycle
- out_data  output  WIDTH  shifted result
- out_tag  output  TAGW  tag of the result
- busy  output  1  OR of all stage valid bits

Behaviour:
- Stage k (k = 1..5) register contents:
  - valid_k
  - data_k
  - remaining shamt bits
  - arith_k
  - tag_k
- Stage k shift rule:
  - Shifts right by 2**(SHW-k) when shamt bit [SHW-k] is set; otherwise passes data through unchanged.
  - Stage 1 consumes bit 4 (shift 16); stage 5 consumes bit 0 (shift 1).
- Fill bits:
  - Logical: 0.
  - Arithmetic: MSB of the operand entering that stage. This equals the original sign, since sra preserves the MSB.
- Outputs are driven directly from stage 5 registers:
  - out_valid = valid_5
  - out_data = data_5
  - out_tag = tag_5
- Latency: operation accepted at edge N has out_valid asserted after edge N+5 when no stall occurs.
- Advance rules:
  - adv_5 = valid_5 & out_ready
  - Stage k (k < 5) may load when !valid_(k+1) | adv_(k+1), i.e. the slot ahead is free.
  - Empty stages (bubbles) collapse under stall.
- Input handshake:
  - in_ready = !valid_1 | (stage 2 can load).
  - Transfer occurs when in_valid & in_ready.
- Throughput: one op/cycle with out_ready held high.
- Stall: with out_ready low, at most 5 ops are held. in_ready drops once all five stages are valid.
- Ordering: results leave strictly in acceptance order; no reordering or duplication.
- Stage invariant: a stage whose valid is 0 holds its data, and its valid only rises on a load.
- flush (sampled at clock edge):
  - Clears all valid_k.
  - An input offered in the same cycle is dropped, even though in_ready may be high.
  - A stage-5 result handshaked in the flush cycle counts as delivered.
  - out_valid is 0 in the cycle after flush.
- Reset (reset_n low, asynchronous, any time including mid-operation):
  - All valid_k = 0, all data/tag/shamt/arith registers = 0.
  - Resulting outputs: out_valid = 0, out_data = 0, out_tag = 0, busy = 0.
  - in_ready = 1 during and after reset.
  - Pipeline contents are lost; nothing is emitted for ops in flight at reset.
- Boundary cases:
  - shamt = 0 returns the operand unchanged for both modes.
  - shamt = 31 on a negative operand: sra gives 0xFFFFFFFF, srl gives 0x00000001.
  - in_arith ignored beyond the fill value; positive operands give identical srl/sra results.

Test Plan:
- Reset, then in_data=0xF0F01234, shamt=4, logical, tag=3 -> out_valid 5 cycles later, out_data=0x0F0F0123, out_tag=3; same operand arith -> 0xFF0F0123.
- in_data=0x80000000: shamt=31 logical -> 0x00000001; shamt=31 arith -> 0xFFFFFFFF; shamt=0 either mode -> 0x80000000.
- Back-to-back stream of 32 ops (shamt = 0..31 on 0xDEADBEEF, alternating arith) with out_ready=1 -> one result per cycle, in order, each matching a reference model.
- Hold out_ready=0 while offering 7 ops -> exactly 5 accepted, in_ready=0 afterwards, out_data stable on op 1; release out_ready -> all 5 emerge in order with no gaps or duplicates, and the remaining 2 are then accepted.
- Fill pipeline with 3 ops, assert flush together with in_valid -> busy=0 and out_valid=0 next cycle, flushed ops and same-cycle input never appear; next op issues normally with 5-cycle latency.
- Assert reset_n low mid-stream, asynchronously between clock edges -> outputs go to zero immediately without a clock edge; after release, a new op (0x00000100 >> 8 logical) gives 0x00000001 with 5-cycle latency.
